// File: rtl/avmm_lvds_bridge_pkg.sv
// Shared definitions for the AVMM-LVDS bridge request link.
// The slave-side serializer and the master-side deserializer both use this
// package, so the frame layout is defined once.
//   ADDR_W / BURSTCNT_W : Avalon address and burstcount widths
//   req_op_t            : request opcode carried in header bits [31:30]
//   REQ_MARKER          : frame marker expected in header bits [29:28]
//   req_hdr_t           : header word overlay
package avmm_lvds_bridge_pkg;

  localparam int ADDR_W     = 32;
  localparam int BURSTCNT_W = 8;

  typedef enum logic [1:0] {
    OP_WR  = 2'd0,
    OP_RD  = 2'd1,
    OP_BWR = 2'd2,
    OP_BRD = 2'd3
  } req_op_t;

  localparam logic [1:0] REQ_MARKER = 2'b01;

  // Header field positions (LSB of each field)
  localparam int HDR_OP_LSB   = 30;
  localparam int HDR_MARK_LSB = 28;
  localparam int HDR_BE_LSB   = 24;
  localparam int HDR_BC_LSB   = 0;

  // Bits between byteenable and burstcount are don't-care.
  typedef struct packed {
    req_op_t                 op;
    logic [1:0]              marker;
    logic [3:0]              byteenable;
    logic [23-BURSTCNT_W:0]  rsvd;
    logic [BURSTCNT_W-1:0]   burstcount;
  } req_hdr_t;

  function automatic logic op_is_burst(input req_op_t op);
    return (op == OP_BWR) || (op == OP_BRD);
  endfunction

  function automatic logic op_is_write(input req_op_t op);
    return (op == OP_WR) || (op == OP_BWR);
  endfunction

endpackage

// File: rtl/avmm_lvds_word_deser.sv
// Lane-to-word assembler for the request link.
// Each valid beat is shifted in, LSB lane first; the beat that completes a
// word is presented combinationally together with word_valid_o so the parser
// can register its outputs one cycle after that final beat.
//   clk_i, rst_i        : link clock, synchronous active-low reset
//   req_data_i          : lane beat
//   req_valid_i         : beat qualifier; low cycles hold all state
//   word_o              : assembled 32-bit word (meaningful with word_valid_o)
//   word_valid_o        : high in the cycle carrying the last beat of a word
module avmm_lvds_word_deser #(
  parameter int REQ_FACTOR = 8,
  parameter int LANE_W     = 32 / REQ_FACTOR
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LANE_W-1:0] req_data_i,
  input  logic              req_valid_i,
  output logic [31:0]       word_o,
  output logic              word_valid_o
);

  localparam int CNT_W = (REQ_FACTOR > 1) ? $clog2(REQ_FACTOR) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(REQ_FACTOR - 1);

  logic [CNT_W-1:0] beat_q;
  logic [31:0]      sr_next;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      beat_q <= '0;
    end else if (req_valid_i) begin
      beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end
  end

  generate
    if (REQ_FACTOR == 1) begin : g_single
      assign sr_next = req_data_i;
    end else begin : g_multi
      // Only the upper beats need storing; the newest beat enters at the top
      // and earlier beats move down, leaving beat 0 at [LANE_W-1:0].
      logic [31-LANE_W:0] sr_q;
      assign sr_next = {req_data_i, sr_q};
      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          sr_q <= '0;
        end else if (req_valid_i) begin
          sr_q <= sr_next[31:LANE_W];
        end
      end
    end
  endgenerate

  assign word_o       = sr_next;
  assign word_valid_o = req_valid_i && (beat_q == LAST_BEAT);

endmodule

// File: rtl/avmm_lvds_req_deser.sv
// Request deserializer, master side of the AVMM-LVDS bridge.
// Rebuilds 32-bit words from the lane stream and parses them into frames of
// header, address and (for writes) data words.
//   clk_i, rst_i            : request link clock, sync active-low reset
//   req_data_i, req_valid_i : lane beat and qualifier
//   cmd_*_o                 : command fields, strobed by cmd_valid_o
//   wdata_valid_o/wdata_o/wdata_last_o : write-data word strobe
//   frame_err_o, err_cnt_o  : malformed-header strobe and saturating count
//   state_dbg_o             : parser state for observation
// Handshake: there is no ready. Every *_valid_o / frame_err_o is a one-cycle
// strobe that downstream must take in that cycle; the associated fields are
// valid with the strobe and hold until the next strobe of the same kind.
module avmm_lvds_req_deser
  import avmm_lvds_bridge_pkg::*;
#(
  parameter int REQ_FACTOR = 8,
  parameter int LANE_W     = 32 / REQ_FACTOR
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [LANE_W-1:0]     req_data_i,
  input  logic                  req_valid_i,
  output logic                  cmd_valid_o,
  output logic [1:0]            cmd_op_o,
  output logic [3:0]            cmd_byteenable_o,
  output logic [BURSTCNT_W-1:0] cmd_burstcount_o,
  output logic [ADDR_W-1:0]     cmd_address_o,
  output logic                  wdata_valid_o,
  output logic [31:0]           wdata_o,
  output logic                  wdata_last_o,
  output logic                  frame_err_o,
  output logic [15:0]           err_cnt_o,
  output logic [1:0]            state_dbg_o
);

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [31:0] word;
  logic        word_valid;

  avmm_lvds_word_deser #(
    .REQ_FACTOR (REQ_FACTOR),
    .LANE_W     (LANE_W)
  ) u_word_deser (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_data_i   (req_data_i),
    .req_valid_i  (req_valid_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  req_hdr_t hdr;
  logic     hdr_bad;

  assign hdr     = req_hdr_t'(word);
  assign hdr_bad = (hdr.marker != REQ_MARKER) ||
                   (op_is_burst(hdr.op) && (hdr.burstcount == '0));

  logic [1:0]            state_q;
  req_op_t               op_q;
  logic [3:0]            be_q;
  logic [BURSTCNT_W-1:0] bc_q;
  logic [31:0]           rem_q;
  logic [15:0]           err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q          <= ST_HDR;
      op_q             <= OP_WR;
      be_q             <= '0;
      bc_q             <= '0;
      rem_q            <= '0;
      err_cnt_q        <= '0;
      cmd_valid_o      <= 1'b0;
      cmd_op_o         <= '0;
      cmd_byteenable_o <= '0;
      cmd_burstcount_o <= '0;
      cmd_address_o    <= '0;
      wdata_valid_o    <= 1'b0;
      wdata_o          <= '0;
      wdata_last_o     <= 1'b0;
      frame_err_o      <= 1'b0;
    end else begin
      cmd_valid_o   <= 1'b0;
      wdata_valid_o <= 1'b0;
      wdata_last_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      if (word_valid) begin
        case (state_q)
          ST_HDR: begin
            if (hdr_bad) begin
              // Stay in HDR: the next word is tried as a header.
              frame_err_o <= 1'b1;
              if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end else begin
              // Header fields are held privately so the visible command
              // fields only change on cmd_valid_o.
              op_q    <= hdr.op;
              be_q    <= op_is_burst(hdr.op) ? 4'hF : hdr.byteenable;
              bc_q    <= op_is_burst(hdr.op) ? hdr.burstcount : BURSTCNT_W'(1);
              state_q <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            cmd_valid_o      <= 1'b1;
            cmd_op_o         <= op_q;
            cmd_byteenable_o <= be_q;
            cmd_burstcount_o <= bc_q;
            cmd_address_o    <= word[ADDR_W-1:0];
            if (op_is_write(op_q)) begin
              rem_q   <= (op_q == OP_WR) ? 32'd1 : 32'(bc_q);
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_HDR;
            end
          end
          ST_DATA: begin
            wdata_valid_o <= 1'b1;
            wdata_o       <= word;
            rem_q         <= rem_q - 32'd1;
            if (rem_q == 32'd1) begin
              wdata_last_o <= 1'b1;
              state_q      <= ST_HDR;
            end
          end
          default: state_q <= ST_HDR;
        endcase
      end
    end
  end

  assign err_cnt_o   = err_cnt_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_avmm_lvds_req_deser.sv
module tb_avmm_lvds_req_deser;

  localparam int RF = 8;
  localparam int LW = 32 / RF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  logic [LW-1:0] req_data_i = '0;
  logic          req_valid_i = 1'b0;
  logic          cmd_valid_o;
  logic [1:0]    cmd_op_o;
  logic [3:0]    cmd_byteenable_o;
  logic [7:0]    cmd_burstcount_o;
  logic [31:0]   cmd_address_o;
  logic          wdata_valid_o;
  logic [31:0]   wdata_o;
  logic          wdata_last_o;
  logic          frame_err_o;
  logic [15:0]   err_cnt_o;
  logic [1:0]    state_dbg_o;

  avmm_lvds_req_deser #(.REQ_FACTOR(RF)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_data_i       (req_data_i),
    .req_valid_i      (req_valid_i),
    .cmd_valid_o      (cmd_valid_o),
    .cmd_op_o         (cmd_op_o),
    .cmd_byteenable_o (cmd_byteenable_o),
    .cmd_burstcount_o (cmd_burstcount_o),
    .cmd_address_o    (cmd_address_o),
    .wdata_valid_o    (wdata_valid_o),
    .wdata_o          (wdata_o),
    .wdata_last_o     (wdata_last_o),
    .frame_err_o      (frame_err_o),
    .err_cnt_o        (err_cnt_o),
    .state_dbg_o      (state_dbg_o)
  );

  // ---------------- scoreboard ----------------
  // Entries carry the cycle at which the strobe must be seen.
  logic [77:0] cmd_q[$];   // {cyc, op, be, bc, addr}
  logic [64:0] wd_q[$];    // {cyc, last, data}
  logic [47:0] err_q[$];   // {cyc, err_cnt}
  int n_vec = 0;
  int n_err = 0;
  int model_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_word(input logic [31:0] w, input int maxgap, output logic [31:0] stamp);
    int gap;
    for (int i = 0; i < RF; i++) begin
      gap = $urandom_range(maxgap);
      repeat (gap) begin
        @(negedge clk);
        req_valid_i = 1'b0;
        req_data_i  = LW'($urandom);
      end
      @(negedge clk);
      req_valid_i = 1'b1;
      req_data_i  = w[i*LW +: LW];
    end
    // Strobe expected in the cycle after the one carrying the last beat.
    stamp = cyc + 32'd1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid_i = 1'b0;
    end
  endtask

  // Reference model at frame level: derive expected strobes from the header
  // fields, then send the words. ndata_lim truncates the data phase.
  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] addr,
                            input logic [31:0] d0, input int maxgap, input int ndata_lim);
    logic [1:0]  op, mk;
    logic [3:0]  be;
    logic [7:0]  bc;
    logic        burst, bad;
    logic [31:0] st, w;
    int          n;
    op    = hdr[31:30];
    mk    = hdr[29:28];
    be    = hdr[27:24];
    bc    = hdr[7:0];
    burst = (op == 2'd2) || (op == 2'd3);
    bad   = (mk != 2'b01) || (burst && bc == 8'd0);
    send_word(hdr, maxgap, st);
    if (bad) begin
      if (model_err < 65535) model_err = model_err + 1;
      err_q.push_back({st, 16'(model_err)});
    end else begin
      send_word(addr, maxgap, st);
      cmd_q.push_back({st, op, (burst ? 4'hF : be), (burst ? bc : 8'd1), addr});
      if (op == 2'd0 || op == 2'd2) begin
        n = (op == 2'd0) ? 1 : int'(bc);
        for (int i = 0; i < n && i < ndata_lim; i++) begin
          w = (i == 0) ? d0 : $urandom;
          send_word(w, maxgap, st);
          wd_q.push_back({st, (i == n - 1), w});
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (cmd_q.size() == 0 && wd_q.size() == 0 && err_q.size() == 0) break;
      @(negedge clk);
    end
    chk("cmd_q_drained", cmd_q.size(), 0);
    chk("wd_q_drained", wd_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  logic [77:0] got_c, exp_c;
  logic [64:0] got_w, exp_w;
  logic [47:0] got_e, exp_e;

  always @(negedge clk) begin
    if (rst_i) begin
      if (cmd_valid_o) begin
        got_c = {cyc, cmd_op_o, cmd_byteenable_o, cmd_burstcount_o, cmd_address_o};
        n_vec = n_vec + 1;
        if (cmd_q.size() == 0) begin
          n_err = n_err + 1;
          $display("FAIL cmd_unexpected: got %h, none expected", got_c);
        end else begin
          exp_c = cmd_q.pop_front();
          if (got_c !== exp_c) begin
            n_err = n_err + 1;
            $display("FAIL cmd {cyc,op,be,bc,addr}: got %h expected %h", got_c, exp_c);
          end
        end
      end
      if (wdata_valid_o) begin
        got_w = {cyc, wdata_last_o, wdata_o};
        n_vec = n_vec + 1;
        if (wd_q.size() == 0) begin
          n_err = n_err + 1;
          $display("FAIL wdata_unexpected: got %h, none expected", got_w);
        end else begin
          exp_w = wd_q.pop_front();
          if (got_w !== exp_w) begin
            n_err = n_err + 1;
            $display("FAIL wdata {cyc,last,data}: got %h expected %h", got_w, exp_w);
          end
        end
      end
      if (frame_err_o) begin
        got_e = {cyc, err_cnt_o};
        n_vec = n_vec + 1;
        if (err_q.size() == 0) begin
          n_err = n_err + 1;
          $display("FAIL frame_err_unexpected: got %h, none expected", got_e);
        end else begin
          exp_e = err_q.pop_front();
          if (got_e !== exp_e) begin
            n_err = n_err + 1;
            $display("FAIL frame_err {cyc,cnt}: got %h expected %h", got_e, exp_e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  op, mk;
    logic [7:0]  bc;
    logic [31:0] hdr;

    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", 32'(cmd_valid_o), 0);
    chk("rst_wdata_valid", 32'(wdata_valid_o), 0);
    chk("rst_frame_err", 32'(frame_err_o), 0);
    chk("rst_err_cnt", 32'(err_cnt_o), 0);
    chk("rst_cmd_address", cmd_address_o, 0);
    chk("rst_wdata", wdata_o, 0);
    rst_i = 1'b1;

    // Single write, back-to-back words
    send_frame(32'h1F00_0001, 32'h0000_0040, 32'hDEAD_BEEF, 0, 99);
    idle(2);
    drain();

    // Burst read: no data phase, byteenable forced
    send_frame(32'hD000_0004, 32'h0000_1234, 32'h0, 0, 99);
    idle(2);
    drain();

    // Burst write of 8 with random gaps
    send_frame(32'h9F00_0008, $urandom, $urandom, 5, 99);
    idle(2);
    drain();

    // Bad marker, then a valid single read
    send_frame(32'h0F00_0001, 32'h0, 32'h0, 0, 99);
    send_frame(32'h5300_0001, 32'h0000_0ABC, 32'h0, 1, 99);
    idle(2);
    drain();
    chk("err_cnt_after_bad_marker", 32'(err_cnt_o), 1);

    // Reset mid-frame: BWR x4 cut after 2 data words plus a partial word
    send_frame(32'h9F00_0004, 32'h0000_0100, $urandom, 0, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid_i = 1'b1;
      req_data_i  = LW'($urandom);
    end
    @(negedge clk);
    rst_i       = 1'b0;
    req_valid_i = 1'b1;
    req_data_i  = LW'($urandom);
    @(negedge clk);
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    model_err   = 0;
    chk("midrst_cmd_address", cmd_address_o, 0);
    chk("midrst_wdata", wdata_o, 0);
    chk("midrst_err_cnt", 32'(err_cnt_o), 0);
    idle(12);
    drain();
    // Single write with burstcount field 0: ignored, reported as 1
    send_frame(32'h1A00_0000, 32'h0000_0200, $urandom, 1, 99);
    idle(2);
    drain();

    // Error counter saturation
    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_cnt_q;
    model_err = 16'hFFFE;
    @(negedge clk);
    chk("err_cnt_preload", 32'(err_cnt_o), 32'hFFFE);
    send_frame(32'h2F00_0001, 32'h0, 32'h0, 0, 99);
    send_frame(32'h8000_0003, 32'h0, 32'h0, 1, 99);
    send_frame(32'h9F00_0000, 32'h0, 32'h0, 0, 99);
    idle(2);
    drain();
    chk("err_cnt_saturated", 32'(err_cnt_o), 32'hFFFF);

    // Random frames
    for (int f = 0; f < 25; f++) begin
      op  = 2'($urandom);
      mk  = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b01;
      bc  = op[1] ? 8'($urandom_range(6)) : 8'($urandom);
      hdr = {op, mk, 4'($urandom), 16'($urandom), bc};
      send_frame(hdr, $urandom, $urandom, 2, 99);
    end
    idle(2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/avmm_lvds_req_deser.md
# avmm_lvds_req_deser

Link-side request deserializer for the AVMM-LVDS bridge master side. It runs in the `req_clk_i` domain and receives the narrow request lane stream produced by the bridge slave side. It reassembles 32-bit words and parses each word stream into request frames (header, address, write data). Frames leave as single-cycle command and write-data strobes into the CDC FIFOs that feed the Avalon master FSMs.

## Interface

Parameters:
- `REQ_FACTOR`, default 8: lane beats per 32-bit word; legal values 1, 2, 4, 8, 16, 32.
- `LANE_W`, default 32/REQ_FACTOR: lane width, derived; must not be overridden.

Ports:
- `clk_i` in 1: request link clock.
- `rst_i` in 1: reset, synchronous, active-low.
- `req_data_i` in LANE_W: lane data.
- `req_valid_i` in 1: lane beat qualifier.
- `cmd_valid_o` out 1: one-cycle strobe, command fields valid.
- `cmd_op_o` out 2: opcode, one of `OP_WR`, `OP_RD`, `OP_BWR`, `OP_BRD`.
- `cmd_byteenable_o` out 4: byteenable; 4'hF for burst ops.
- `cmd_burstcount_o` out BURSTCNT_W: burstcount; 1 for single ops.
- `cmd_address_o` out ADDR_W: word address.
- `wdata_valid_o` out 1: one-cycle strobe per write-data word.
- `wdata_o` out 32: write data word.
- `wdata_last_o` out 1: marks the last data word of a frame.
- `frame_err_o` out 1: one-cycle strobe on a malformed header.
- `err_cnt_o` out 16: count of malformed headers; saturates at 16'hFFFF.

## Operation

Word assembly:
- Each cycle with `req_valid_i`=1 shifts one beat into the word register, LSB lane first. Beat 0 fills bits [LANE_W-1:0].
- Beat counter runs 0..REQ_FACTOR-1 and wraps. A word completes on beat REQ_FACTOR-1.
- `req_valid_i`=0 cycles hold all state. Gaps of any length are allowed, mid-word included.

Frame format, in 32-bit words:
- Header word fields:
  - [31:30] opcode: 0 WR, 1 RD, 2 BWR, 3 BRD.
  - [29:28] must be 2'b01 (frame marker).
  - [27:24] byteenable.
  - [BURSTCNT_W-1:0] burstcount.
  - All other bits are ignored.
- Address word: bits [ADDR_W-1:0] carry the address.
- Data words follow only for write ops: 1 word for WR, burstcount words for BWR.

FSM states and transitions:
- HDR:
  - Valid header goes to ADDR.
  - Invalid header (marker ≠ 2'b01, or burst op with burstcount 0) pulses `frame_err_o`, increments `err_cnt_o`, and stays in HDR. The parser resynchronises on the next word.
- ADDR:
  - On address word completion, emit `cmd_valid_o`.
  - Then go to DATA for WR/BWR, or to HDR for RD/BRD.
- DATA:
  - Each completed word emits `wdata_valid_o`.
  - A 32-bit-wide remaining-count register is loaded with 1 (WR) or burstcount (BWR).
  - On the last word, assert `wdata_last_o` and go to HDR.
- For single ops the header burstcount field is ignored and reported as 1. For burst ops byteenable is forced to 4'hF.

## Timing

- Reset values: all outputs 0; FSM in HDR; beat counter 0; error counter 0.
- While `rst_i`=0, beats are ignored. Reset mid-frame discards the partial word and frame with no output strobe.
- Latency: `cmd_valid_o`, `wdata_valid_o` and `frame_err_o` assert exactly 1 cycle after the cycle carrying the final beat of the relevant word. Outputs are registered.
- Command fields and `wdata_o` hold their values until the next strobe.
- No backpressure exists. Strobes are never stalled; downstream must accept at full rate.
- Minimum spacing between strobes is REQ_FACTOR cycles. With REQ_FACTOR=1 that allows a strobe every cycle.
- At saturation, `err_cnt_o` holds 16'hFFFF; `frame_err_o` still pulses.

## Structure

- `avmm_lvds_bridge_pkg` holds:
  - ADDR_W and BURSTCNT_W;
  - the opcode enum `req_op_t`;
  - the `REQ_MARKER` constant;
  - header field bit positions;
  - a `req_hdr_t` packed struct.
- The slave-side serializer shares these definitions from the same package.
- Sub-module `avmm_lvds_word_deser` (beat counter plus shift register) outputs `word_o` and `word_valid_o`. The FSM lives in the top module.

## Test plan

All scenarios use REQ_FACTOR=8 (4-bit lanes).
- Single write: header 0x1F00_0001, address 0x0000_0040, data 0xDEAD_BEEF sent back-to-back.
  - `cmd_valid_o` fires with op WR, byteenable 4'hF, burstcount 1, address 0x40.
  - `wdata_valid_o` then fires with 0xDEADBEEF and `wdata_last_o`=1, 8 cycles after the command strobe.
- Burst read: header 0xD000_0004 followed by an address word.
  - One `cmd_valid_o` with op BRD and burstcount 4.
  - No `wdata_valid_o`; the FSM returns to HDR.
- Burst write of 8 words with random `req_valid_i` gaps of 0–5 cycles.
  - 8 `wdata_valid_o` strobes, data in order; `wdata_last_o` only on the 8th.
- Bad marker: header 0x0F00_0001, then a valid single-read frame.
  - One `frame_err_o` pulse; `err_cnt_o`=1.
  - The read command is then decoded correctly.
- Assert `rst_i`=0 for 1 cycle after the address word of a BWR with burstcount 4, having sent 2 data words.
  - No further strobes.
  - A new WR frame sent afterwards decodes correctly.
- Error counter saturation: force `err_cnt_o` to 16'hFFFE, then send 3 bad headers.
  - Counter stops at 16'hFFFF.
  - 3 `frame_err_o` pulses observed.
